// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes and initiator FSM states
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        RSP
    } axil_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator fed by a valid/ready command port
module axi_lite_master
    import axil_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 16,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    axil_state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  write_q;
    logic                  aw_done;
    logic                  w_done;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;

    // Every handshake-facing output decodes registered state only.
    assign cmd_ready      = (state == IDLE);
    assign rsp_valid      = (state == RSP);
    assign m_axil_awvalid = (state == WRITE) && !aw_done;
    assign m_axil_wvalid  = (state == WRITE) && !w_done;
    assign m_axil_bready  = (state == WRESP);
    assign m_axil_arvalid = (state == READ);
    assign m_axil_rready  = (state == RDATA);

    assign m_axil_awaddr  = addr_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_awprot  = PROT;
    assign m_axil_arprot  = PROT;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = m_axil_awvalid && m_axil_awready;
    assign w_hs   = m_axil_wvalid && m_axil_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_next = cmd_write ? WRITE : READ;
            WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WRESP;
            WRESP:   if (m_axil_bvalid) state_next = RSP;
            READ:    if (m_axil_arready) state_next = RDATA;
            RDATA:   if (m_axil_rvalid) state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= AXIL_RESP_OKAY;
        end else begin
            if (cmd_hs) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            if ((state == WRESP) && m_axil_bvalid) begin
                rsp_write <= write_q;
                rsp_rdata <= '0;
                rsp_resp  <= m_axil_bresp;
            end
            if ((state == RDATA) && m_axil_rvalid) begin
                rsp_write <= write_q;
                rsp_rdata <= m_axil_rdata;
                rsp_resp  <= m_axil_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - self-checking bench with a delay-programmable AXI4-Lite responder
module tb_axi_lite_master;
    import axil_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;

    always #5 clk = ~clk;

    axi_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    int total = 0;
    int bad   = 0;

    int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] force_bresp = 2'b00, force_rresp = 2'b00;
    bit [31:0]  mem [256];
    bit [31:0]  ref_mem [256];

    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic        got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [15:0] aw_addr_l = 16'h0, ar_addr_l = 16'h0;
    logic [31:0] w_data_l = 32'h0;
    logic [3:0]  w_strb_l = 4'h0;

    // Responder: decides at each falling edge what the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
            got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (b_pend) begin
                bvalid = 1'b0; b_pend = 1'b0; got_aw = 1'b0; got_w = 1'b0; b_wait = 0;
            end else if (got_aw && got_w) begin
                if (!bvalid) begin
                    if (b_wait == b_delay) begin
                        if (force_bresp == AXIL_RESP_OKAY)
                            for (int b = 0; b < 4; b++)
                                if (w_strb_l[b]) mem[aw_addr_l[9:2]][8*b +: 8] = w_data_l[8*b +: 8];
                        bresp  = force_bresp;
                        bvalid = 1'b1;
                    end else begin
                        b_wait++;
                    end
                end
                if (bvalid && bready) b_pend = 1'b1;
            end
            if (awvalid) begin
                if (aw_wait == aw_delay) begin
                    awready = 1'b1; got_aw = 1'b1; aw_addr_l = awaddr;
                end else begin
                    awready = 1'b0; aw_wait++;
                end
            end else begin
                awready = 1'b0; aw_wait = 0;
            end
            if (wvalid) begin
                if (w_wait == w_delay) begin
                    wready = 1'b1; got_w = 1'b1; w_data_l = wdata; w_strb_l = wstrb;
                end else begin
                    wready = 1'b0; w_wait++;
                end
            end else begin
                wready = 1'b0; w_wait = 0;
            end
            if (r_pend) begin
                rvalid = 1'b0; r_pend = 1'b0; got_ar = 1'b0; r_wait = 0;
            end else if (got_ar) begin
                if (!rvalid) begin
                    if (r_wait == r_delay) begin
                        rvalid = 1'b1; rdata = mem[ar_addr_l[9:2]]; rresp = force_rresp;
                    end else begin
                        r_wait++;
                    end
                end
                if (rvalid && rready) r_pend = 1'b1;
            end
            if (arvalid) begin
                if (ar_wait == ar_delay) begin
                    arready = 1'b1; got_ar = 1'b1; ar_addr_l = araddr;
                end else begin
                    arready = 1'b0; ar_wait++;
                end
            end else begin
                arready = 1'b0; ar_wait = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1 after acceptance.
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: cmd_ready got 0 expected 1");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rr, output logic rw, output int lat);
        int n;
        n = 1;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL rsp_timeout: rsp_valid got 0 expected 1");
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, d, mask, exp_rd;
        logic [1:0]  rr, err;
        logic        rw, w;
        logic [7:0]  idx;
        logic [3:0]  s;
        int          lat, exp_lat, mx, n;

        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h00000000, 2'b00};
        vecs[1] = '{1'b0, 16'h0010, 32'h0BADF00D, 4'hF, 32'hDEADBEEF, 2'b00};
        vecs[2] = '{1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF, 32'h00000000, 2'b00};
        vecs[3] = '{1'b1, 16'h0020, 32'h0000AAAA, 4'h3, 32'h00000000, 2'b00};
        vecs[4] = '{1'b0, 16'h0020, 32'h0BADF00D, 4'hF, 32'hFFFFAAAA, 2'b00};
        vecs[5] = '{1'b1, 16'h0030, 32'h12345678, 4'h0, 32'h00000000, 2'b00};
        vecs[6] = '{1'b0, 16'h0030, 32'h0BADF00D, 4'hF, 32'h00000000, 2'b00};
        vecs[7] = '{1'b1, 16'h0030, 32'hA5C3E1F7, 4'h9, 32'h00000000, 2'b00};
        vecs[8] = '{1'b0, 16'h0030, 32'h0BADF00D, 4'hF, 32'hA50000F7, 2'b00};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}), 64'(7'b0000001));
        check("reset_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(35'h0));
        check("prot", 64'({awprot, arprot}), 64'(6'b000000));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s);
            check($sformatf("vec%0d_first_valids", i), 64'({awvalid, wvalid, arvalid}),
                  64'(vecs[i].w ? 3'b110 : 3'b001));
            wait_rsp(rd, rr, rw, lat);
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_resp", i), 64'(rr), 64'(vecs[i].exp_resp));
            check($sformatf("vec%0d_write", i), 64'(rw), 64'(vecs[i].w));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
        end

        // AW and W completing in opposite orders.
        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 0 : 2;
            w_delay  = (k == 0) ? 3 : 0;
            mx = (aw_delay > w_delay) ? aw_delay : w_delay;
            issue(1'b1, 16'h0060, 32'hCAFE0000 + 32'(k), 4'hF);
            for (int c = 1; c <= 2 + mx; c++) begin
                check($sformatf("order%0d_cycle%0d", k, c), 64'({awvalid, wvalid, bready}),
                      64'({c <= 1 + aw_delay, c <= 1 + w_delay, c >= 2 + mx}));
                @(negedge clk);
            end
            wait_rsp(rd, rr, rw, lat);
            check($sformatf("order%0d_resp", k), 64'({rw, rr}), 64'(3'b100));
        end
        aw_delay = 0; w_delay = 0;

        // SLVERR with the response held off.
        force_bresp = AXIL_RESP_SLVERR;
        rsp_ready = 1'b0;
        issue(1'b1, 16'h0050, 32'h55667788, 4'hF);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 6; c++) begin
            check($sformatf("stall_hold%0d", c),
                  64'({rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata}),
                  64'({1'b1, 1'b0, 1'b1, 2'b10, 32'h0}));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
        force_bresp = AXIL_RESP_OKAY;
        issue(1'b0, 16'h0050, 32'h0, 4'h0);
        wait_rsp(rd, rr, rw, lat);
        check("slverr_not_stored", 64'(rd), 64'(32'h0));
        force_rresp = AXIL_RESP_DECERR;
        issue(1'b0, 16'h0010, 32'h0, 4'h0);
        wait_rsp(rd, rr, rw, lat);
        check("decerr_read", 64'({rr, rd}), 64'({2'b11, 32'hDEADBEEF}));
        force_rresp = AXIL_RESP_OKAY;

        // Reset while waiting for B.
        b_delay = 3;
        issue(1'b1, 16'h0040, 32'h11223344, 4'hF);
        @(negedge clk);
        check("in_wresp", 64'({bready, awvalid, wvalid}), 64'(3'b100));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_reset",
              64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}), 64'(7'b0000001));
        b_delay = 0;
        issue(1'b0, 16'h0040, 32'h0, 4'h0);
        wait_rsp(rd, rr, rw, lat);
        check("after_reset_read", 64'({rr, rd}), 64'(34'h0));

        // Randomized traffic against a memory model with byte-lane masking.
        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom_range(0, 1));
            idx = 8'(64 + $urandom_range(0, 15));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            aw_delay = int'($urandom_range(0, 3));
            w_delay  = int'($urandom_range(0, 3));
            b_delay  = int'($urandom_range(0, 3));
            ar_delay = int'($urandom_range(0, 3));
            r_delay  = int'($urandom_range(0, 3));
            err = ($urandom_range(0, 5) == 0) ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
            if (w) begin
                force_bresp = err;
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                if (err == AXIL_RESP_OKAY) ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
                exp_rd  = 32'h0;
                exp_lat = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
            end else begin
                force_rresp = err;
                exp_rd  = ref_mem[idx];
                exp_lat = 3 + ar_delay + r_delay;
            end
            issue(w, {6'b0, idx, 2'b00}, d, s);
            wait_rsp(rd, rr, rw, lat);
            check($sformatf("rand%0d_rdata", i), 64'(rd), 64'(exp_rd));
            check($sformatf("rand%0d_resp_write", i), 64'({rr, rw}), 64'({err, w}));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat));
            force_bresp = AXIL_RESP_OKAY;
            force_rresp = AXIL_RESP_OKAY;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
